seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.
//  Scans digits at a programmable rate. Double-buffers display data so that updates
//  take effect only at frame boundaries, which prevents tearing. Adds per-digit blanking,
//  leading-zero suppression and 16-level PWM brightness.
//  Sits between the register/debug data path and the board display pins.
// PARAMETERS
//  NUM_DIGITS  4   digits driven, 2..8; digit 0 = least significant nibble
//  DIV_LOG2    17  scan slot length = 2**DIV_LOG2 in_clk cycles; must be >= 4
// PORTS
//  in_clk      in   1             system clock
//  reset       in   1             asynchronous, active-high reset
//  data_in     in   4*NUM_DIGITS  hex value to display
//  data_we     in   1             write strobe; data_in captured into shadow register
//  lz_en       in   1             1 = suppress leading zeros
//  brightness  in   4             PWM level; 0 = 1/16 duty, 15 = full on
//  blank_mask  in   NUM_DIGITS    bit i = 1 forces digit i dark
//  anode       out  NUM_DIGITS    active-low digit enables, one-hot-low
//  catode      out  7             active-high segments {g,f,e,d,c,b,a}
//  frame_done  out  1             1-cycle pulse when active data reloads at frame start
// BEHAVIOUR
//  - Reset values: anode all 1s, catode 7'h00, frame_done 0; slot counter 0,
//    digit index 0, shadow and active data 0. A reset mid-frame returns all of these
//    to reset values immediately.
//  - Slot counter (DIV_LOG2 bits) free-runs. tick = (counter == all 1s).
//  - Digit index advances 0,1,..,NUM_DIGITS-1,0 on each tick and wraps to 0
//    after NUM_DIGITS-1.
//  - data_we=1 in any cycle: shadow <= data_in. Multiple writes in one frame: last wins.
//  - Frame boundary = tick while index == NUM_DIGITS-1. In that cycle:
//    active <= (data_we ? data_in : shadow), and frame_done = 1 in the next cycle.
//    A write in the boundary cycle is therefore shown in the same new frame.
//  - Decode: 0..F -> 3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,39,5E,79,71.
//  - Digit i (i>0) is leading-zero when lz_en=1 and active nibbles i..N-1 are all 0.
//    Digit 0 is never suppressed, so value 0 shows "0".
//  - A digit is dark when it is blank_mask[i], leading-zero, or PWM-off.
//    Dark: anode all 1s, catode 7'h00.
//  - PWM-on when counter[DIV_LOG2-1 -: 4] <= brightness. brightness is sampled live.
//  - Outputs are registered. anode/catode reflect the index and counter of the
//    previous cycle (1-cycle latency). No glitches between slots.
//  - Exactly one anode bit is low when lit; none are low when dark.
// CONFIGURATION
//  SEG7_DP_EN defined:
//    - adds input dp_in[NUM_DIGITS-1:0] and output dp (active-high decimal point).
//    - dp_in is double-buffered with data_in via the same data_we and frame-boundary rules.
//    - dp = dp_active[index] when the digit is lit, else 0; dp resets to 0.
//    - A dp bit prevents leading-zero suppression of its own digit and all lower digits.
//  SEG7_DP_EN undefined: no dp ports and no dp logic.
// TESTING (NUM_DIGITS=4, DIV_LOG2=4, brightness=15, lz_en=0, blank_mask=0 unless noted)
//  1. Reset, then write 16'h1234 -> after the first boundary, anode cycles
//     1110,1101,1011,0111 with catode 4F,5B,06... wait: order follows index 0..3:
//     catode 66,4F,5B,06; each slot is 16 cycles.
//  2. Write 16'hABCD mid-frame -> display unchanged until the boundary;
//     frame_done pulses once; the next frame shows D,C,B,A (5E,39,7C,77).
//  3. lz_en=1, data 16'h0050 -> digits 3 and 2 dark; digit 1 shows 6D, digit 0 shows 3F.
//     Data 16'h0000 -> only digit 0 lit, showing 3F.
//  4. brightness=3 -> each slot lit for 4 of 16 cycles (counter top nibble 0..3).
//     blank_mask=4'b0100 -> digit 2 never lit.
//  5. Assert reset mid-slot -> same cycle anode=1111, catode=00, frame_done=0;
//     after release, the display shows 0000 until the next write and boundary.
//  6. SEG7_DP_EN, dp_in=4'b0010, lz_en=1, data 16'h0000 -> digits 1 and 0 lit,
//     dp=1 only during the digit-1 slot.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous double buffering.
// Optional decimal-point support is compiled in when SEG7_DP_EN is defined.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_LOG2   = 17
) (
    input  logic                    in_clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    data_we,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              catode,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0]     slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [4*NUM_DIGITS-1:0] active_data;
    logic                    tick;
    logic                    frame_boundary;

    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [NUM_DIGITS-1:0]   anode_sel;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic                    cur_lz;
    logic                    pwm_on;
    logic                    lit;

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_shadow;
    logic [NUM_DIGITS-1:0]   dp_active;
    logic                    cur_dp;
`endif

    function automatic logic [6:0] seg7_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h67;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign tick           = &slot_cnt;
    assign frame_boundary = tick && (digit_idx == LAST_IDX);

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Active data only changes on the frame boundary so a frame never shows a mix of old and new values.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            shadow_data <= '0;
            active_data <= '0;
        end else begin
            if (data_we) begin
                shadow_data <= data_in;
            end
            if (frame_boundary) begin
                active_data <= data_we ? data_in : shadow_data;
            end
        end
    end

`ifdef SEG7_DP_EN
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            dp_shadow <= '0;
            dp_active <= '0;
        end else begin
            if (data_we) begin
                dp_shadow <= dp_in;
            end
            if (frame_boundary) begin
                dp_active <= data_we ? dp_in : dp_shadow;
            end
        end
    end
`endif

    // Scan from the top digit down; once a non-zero nibble (or a lit dp) is seen, nothing below is suppressed.
    always_comb begin : lz_scan
        logic keep;
        keep   = 1'b0;
        lz_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            keep = keep | (active_data[4*i +: 4] != 4'h0);
`ifdef SEG7_DP_EN
            keep = keep | dp_active[i];
`endif
            lz_vec[i] = lz_en && !keep && (i != 0);
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_blank  = 1'b0;
        cur_lz     = 1'b0;
        anode_sel  = '1;
`ifdef SEG7_DP_EN
        cur_dp     = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nibble   = active_data[4*i +: 4];
                cur_blank    = blank_mask[i];
                cur_lz       = lz_vec[i];
                anode_sel[i] = 1'b0;
`ifdef SEG7_DP_EN
                cur_dp       = dp_active[i];
`endif
            end
        end
    end

    assign pwm_on = (slot_cnt[DIV_LOG2-1 -: 4] <= brightness);
    assign lit    = pwm_on && !cur_blank && !cur_lz;

    // Registering the pin drivers keeps the anode/segment switch glitch-free at slot changes.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            anode      <= '1;
            catode     <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            anode      <= lit ? anode_sel : '1;
            catode     <= lit ? seg7_decode(cur_nibble) : 7'h00;
            frame_done <= frame_boundary;
        end
    end

`ifdef SEG7_DP_EN
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            dp <= 1'b0;
        end else begin
            dp <= lit && cur_dp;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl (4 digits, 16-cycle slots) against a cycle-count reference model.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int DL = 4;

    logic          in_clk     = 1'b0;
    logic          reset      = 1'b0;
    logic [15:0]   data_in    = 16'h0;
    logic          data_we    = 1'b0;
    logic          lz_en      = 1'b0;
    logic [3:0]    brightness = 4'hF;
    logic [3:0]    blank_mask = 4'h0;
    logic [3:0]    anode;
    logic [6:0]    catode;
    logic          frame_done;
`ifdef SEG7_DP_EN
    logic [3:0]    dp_in    = 4'h0;
    logic          dp;
    logic [3:0]    dp_drive = 4'h0;
    logic [3:0]    m_dp_shadow;
    logic [3:0]    m_dp_active;
`endif

    int            total = 0;
    int            bad   = 0;
    int            cyc;
    logic [15:0]   m_shadow;
    logic [15:0]   m_active;
    logic [6:0]    seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV_LOG2(DL)) dut (
        .in_clk     (in_clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_we    (data_we),
        .lz_en      (lz_en),
        .brightness (brightness),
        .blank_mask (blank_mask),
`ifdef SEG7_DP_EN
        .dp_in      (dp_in),
        .dp         (dp),
`endif
        .anode      (anode),
        .catode     (catode),
        .frame_done (frame_done)
    );

    always #5 in_clk = ~in_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, observed, expected);
        end
    endtask

    function automatic logic [15:0] randData();
        return 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
    endfunction

    // One clock: drive inputs at the falling edge, predict the registered outputs, check after the next fall.
    task automatic applyStimulus(input logic [15:0] d, input logic we, input logic lz,
                                 input logic [3:0] br, input logic [3:0] bm);
        int          digit;
        int          phase;
        logic [15:0] upper;
        logic        suppressed;
        logic        lit;
        logic        exp_fd;
        logic [3:0]  one_hot;
        logic [3:0]  exp_anode;
        logic [6:0]  exp_cat;
`ifdef SEG7_DP_EN
        logic        exp_dp;
`endif
        data_in    = d;
        data_we    = we;
        lz_en      = lz;
        brightness = br;
        blank_mask = bm;
`ifdef SEG7_DP_EN
        dp_in      = dp_drive;
`endif
        digit      = (cyc / 16) % ND;
        phase      = cyc % 16;
        upper      = m_active >> (4 * digit);
        suppressed = lz && (digit > 0) && (upper == 16'h0);
`ifdef SEG7_DP_EN
        suppressed = suppressed && ((m_dp_active >> digit) == 4'h0);
`endif
        lit        = (phase <= int'(br)) && !bm[digit] && !suppressed;
        one_hot    = 4'b0001 << digit;
        exp_anode  = lit ? ~one_hot : 4'hF;
        exp_cat    = lit ? seg_tab[upper[3:0]] : 7'h00;
`ifdef SEG7_DP_EN
        exp_dp     = lit && m_dp_active[digit];
`endif
        exp_fd     = (phase == 15) && (digit == ND - 1);
        if (exp_fd) begin
            m_active = we ? d : m_shadow;
`ifdef SEG7_DP_EN
            m_dp_active = we ? dp_drive : m_dp_shadow;
`endif
        end
        if (we) begin
            m_shadow = d;
`ifdef SEG7_DP_EN
            m_dp_shadow = dp_drive;
`endif
        end
        cyc++;
        @(posedge in_clk);
        @(negedge in_clk);
        checkOutput("anode", 32'(anode), 32'(exp_anode));
        checkOutput("catode", 32'(catode), 32'(exp_cat));
        checkOutput("frame_done", 32'(frame_done), 32'(exp_fd));
`ifdef SEG7_DP_EN
        checkOutput("dp", 32'(dp), 32'(exp_dp));
`endif
    endtask

    task automatic applyReset();
        reset   = 1'b1;
        data_we = 1'b0;
        #1;
        checkOutput("rst_anode", 32'(anode), 32'hF);
        checkOutput("rst_catode", 32'(catode), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
`ifdef SEG7_DP_EN
        checkOutput("rst_dp", 32'(dp), 32'h0);
        m_dp_shadow = 4'h0;
        m_dp_active = 4'h0;
`endif
        cyc      = 0;
        m_shadow = 16'h0;
        m_active = 16'h0;
        @(negedge in_clk);
        @(negedge in_clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input logic lz, input logic [3:0] br, input logic [3:0] bm);
        for (int k = 0; k < n; k++) applyStimulus(randData(), 1'b0, lz, br, bm);
    endtask

    task automatic idleUntil(input int modulus, input int target);
        while ((cyc % modulus) != target) applyStimulus(randData(), 1'b0, 1'b0, 4'hF, 4'h0);
    endtask

    initial begin
        logic [3:0] rbm;
        @(negedge in_clk);
        applyReset();

        applyStimulus(16'h1234, 1'b1, 1'b0, 4'hF, 4'h0);
        idle(140, 1'b0, 4'hF, 4'h0);

        idleUntil(64, 30);
        applyStimulus(16'hABCD, 1'b1, 1'b0, 4'hF, 4'h0);
        idle(110, 1'b0, 4'hF, 4'h0);

        applyStimulus(16'h0050, 1'b1, 1'b1, 4'hF, 4'h0);
        idle(130, 1'b1, 4'hF, 4'h0);
        applyStimulus(16'h0000, 1'b1, 1'b1, 4'hF, 4'h0);
        idle(130, 1'b1, 4'hF, 4'h0);

        applyStimulus(16'h8E9F, 1'b1, 1'b0, 4'h3, 4'b0100);
        idle(130, 1'b0, 4'h3, 4'b0100);

        idleUntil(64, 63);
        applyStimulus(16'h6A07, 1'b1, 1'b0, 4'hF, 4'h0);
        idle(70, 1'b0, 4'hF, 4'h0);

        idleUntil(16, 7);
        applyReset();
        idle(140, 1'b0, 4'hF, 4'h0);

`ifdef SEG7_DP_EN
        dp_drive = 4'b0010;
        applyStimulus(16'h0000, 1'b1, 1'b1, 4'hF, 4'h0);
        idle(130, 1'b1, 4'hF, 4'h0);
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                applyReset();
            end else begin
                rbm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
`ifdef SEG7_DP_EN
                dp_drive = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
`endif
                applyStimulus(randData(), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 15)), rbm);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
